// File: rtl/game_state_ctrl.sv
// Game-flow controller: title, play, optional pause and game-over display.
// Tracks player health from damage strobes and drives the game-over timer
// (start pulse, 60 Hz tick from vsync, done input).
// Optional feature macro: GAME_PAUSE_EN adds the PAUSED state and pause button.
module game_state_ctrl #(
  parameter int unsigned HEALTH_MAX = 100,
  parameter int unsigned HEALTH_W   = 7,
  parameter int unsigned DMG_W      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vsync,
  input  logic                btn_start,
  input  logic                btn_pause,
  input  logic                hit_valid,
  input  logic [DMG_W-1:0]    hit_dmg,
  input  logic                timer_done,
  output logic                timer_start,
  output logic                timer_tick,
  output logic [1:0]          state,
  output logic [HEALTH_W-1:0] health,
  output logic                game_active,
  output logic                gameover_disp
);

  localparam int unsigned CalcW = (HEALTH_W > DMG_W) ? HEALTH_W : DMG_W;
  localparam logic [HEALTH_W-1:0] HealthInit = HEALTH_W'(HEALTH_MAX);

  typedef enum logic [1:0] {
    StTitle    = 2'b00,
    StPlaying  = 2'b01,
    StGameover = 2'b10,
    StPaused   = 2'b11
  } state_e;

  state_e              state_q;
  logic [HEALTH_W-1:0] health_q;
  logic                timer_start_q;
  logic                timer_tick_q;

  logic vsync_q, vsync_prev_q;
  logic start_q, start_prev_q;
  logic vsync_rise, start_rise, pause_rise;

  // Input sample and previous-sample registers; preset to 1 so a level held
  // high through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vsync_q      <= 1'b1;
      vsync_prev_q <= 1'b1;
      start_q      <= 1'b1;
      start_prev_q <= 1'b1;
    end else begin
      vsync_q      <= vsync;
      vsync_prev_q <= vsync_q;
      start_q      <= btn_start;
      start_prev_q <= start_q;
    end
  end

  assign vsync_rise = vsync_q & ~vsync_prev_q;
  assign start_rise = start_q & ~start_prev_q;

`ifdef GAME_PAUSE_EN
  logic pause_q, pause_prev_q;

  // Pause button edge detector, present only with the pause feature.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pause_q      <= 1'b1;
      pause_prev_q <= 1'b1;
    end else begin
      pause_q      <= btn_pause;
      pause_prev_q <= pause_q;
    end
  end

  assign pause_rise = pause_q & ~pause_prev_q;
`else
  logic unused_btn_pause;
  assign unused_btn_pause = btn_pause;
  assign pause_rise       = 1'b0;
`endif

  // Free-running frame tick, one cycle per detected vsync rise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_tick_q <= 1'b0;
    end else begin
      timer_tick_q <= vsync_rise;
    end
  end

  logic [CalcW-1:0]    health_ext, dmg_ext, health_diff;
  logic [HEALTH_W-1:0] health_hit;

  // Health after the current hit, saturating at zero.
  always_comb begin
    health_ext  = CalcW'(health_q);
    dmg_ext     = CalcW'(hit_dmg);
    health_diff = health_ext - dmg_ext;
    health_hit  = (dmg_ext >= health_ext) ? '0 : health_diff[HEALTH_W-1:0];
  end

  // Game-flow FSM with health and timer-start registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StTitle;
      health_q      <= HealthInit;
      timer_start_q <= 1'b0;
    end else begin
      timer_start_q <= 1'b0;
      unique case (state_q)
        StTitle: begin
          health_q <= HealthInit;
          if (start_rise) state_q <= StPlaying;
        end
        StPlaying: begin
          if (hit_valid) health_q <= health_hit;
          // A fatal hit wins over a same-cycle pause edge.
          if (hit_valid && (health_hit == '0)) begin
            state_q       <= StGameover;
            timer_start_q <= 1'b1;
          end else if (pause_rise) begin
            state_q <= StPaused;
          end
        end
        StGameover: begin
          // timer_done may still be high from the previous run during the
          // start-pulse cycle, so only honour it afterwards.
          if (!timer_start_q && timer_done) begin
            state_q  <= StTitle;
            health_q <= HealthInit;
          end
        end
        StPaused: begin
`ifdef GAME_PAUSE_EN
          if (pause_rise) state_q <= StPlaying;
`else
          state_q <= StTitle;
`endif
        end
      endcase
    end
  end

  assign state         = state_q;
  assign health        = health_q;
  assign timer_start   = timer_start_q;
  assign timer_tick    = timer_tick_q;
  assign game_active   = (state_q == StPlaying);
  assign gameover_disp = (state_q == StGameover);

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: a cycle model pushes expected
// outputs to a scoreboard queue as stimulus is driven; each queued entry is
// popped and compared after the clock edge. Directed checks use constants.
module tb_game_state_ctrl;

  localparam int HealthMax = 100;

`ifdef GAME_PAUSE_EN
  localparam bit PauseEn = 1'b1;
`else
  localparam bit PauseEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, vsync, btn_start, btn_pause, hit_valid, timer_done;
  logic [3:0] hit_dmg;
  logic       timer_start, timer_tick, game_active, gameover_disp;
  logic [1:0] state;
  logic [6:0] health;

  game_state_ctrl #(
    .HEALTH_MAX (HealthMax),
    .HEALTH_W   (7),
    .DMG_W      (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .vsync         (vsync),
    .btn_start     (btn_start),
    .btn_pause     (btn_pause),
    .hit_valid     (hit_valid),
    .hit_dmg       (hit_dmg),
    .timer_done    (timer_done),
    .timer_start   (timer_start),
    .timer_tick    (timer_tick),
    .state         (state),
    .health        (health),
    .game_active   (game_active),
    .gameover_disp (gameover_disp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [6:0] hp;
    logic       ts;
    logic       tick;
    logic       act;
    logic       disp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tick_cnt = 0;
  int   vs_period = 0;
  int   vs_cnt = 0;

  // Reference model state
  logic m_vs_q, m_vs_p, m_bs_q, m_bs_p, m_bp_q, m_bp_p;
  logic [1:0] m_state;
  int   m_health;
  logic m_ts, m_tick;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    logic vr, sr, pr, ts_prev;
    int   nh;
    exp_t e;
    if (!reset) begin
      {m_vs_q, m_vs_p, m_bs_q, m_bs_p, m_bp_q, m_bp_p} = 6'b111111;
      m_state = 2'd0; m_health = HealthMax; m_ts = 1'b0; m_tick = 1'b0;
    end else begin
      vr = m_vs_q & ~m_vs_p;
      sr = m_bs_q & ~m_bs_p;
      pr = PauseEn & m_bp_q & ~m_bp_p;
      m_tick = vr;
      ts_prev = m_ts;
      m_ts = 1'b0;
      case (m_state)
        2'd0: begin
          m_health = HealthMax;
          if (sr) m_state = 2'd1;
        end
        2'd1: begin
          if (hit_valid) begin
            nh = m_health - int'(hit_dmg);
            if (nh < 0) nh = 0;
            m_health = nh;
          end
          if (hit_valid && m_health == 0) begin
            m_state = 2'd2; m_ts = 1'b1;
          end else if (pr) begin
            m_state = 2'd3;
          end
        end
        2'd2: if (!ts_prev && timer_done) begin m_state = 2'd0; m_health = HealthMax; end
        default: if (pr) m_state = 2'd1;
      endcase
      m_vs_p = m_vs_q; m_vs_q = vsync;
      m_bs_p = m_bs_q; m_bs_q = btn_start;
      m_bp_p = m_bp_q; m_bp_q = btn_pause;
    end
    e.st = m_state; e.hp = 7'(m_health); e.ts = m_ts; e.tick = m_tick;
    e.act = (m_state == 2'd1); e.disp = (m_state == 2'd2);
    sb_q.push_back(e);
  endtask

  // One clock: drive vsync pattern, push expectation, sample #1 after edge.
  task automatic cycle();
    exp_t e;
    if (vs_period > 0) begin
      vsync = (vs_cnt % vs_period) < (vs_period / 2);
      vs_cnt++;
    end
    model_step();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq("state", 32'(state), 32'(e.st));
      check_eq("health", 32'(health), 32'(e.hp));
      check_eq("timer_start", 32'(timer_start), 32'(e.ts));
      check_eq("timer_tick", 32'(timer_tick), 32'(e.tick));
      check_eq("game_active", 32'(game_active), 32'(e.act));
      check_eq("gameover_disp", 32'(gameover_disp), 32'(e.disp));
    end
    if (timer_tick) tick_cnt++;
  endtask

  task automatic press_start();
    btn_start = 1'b0; cycle();
    btn_start = 1'b1; cycle(); cycle();
  endtask

  task automatic hit(input int dmg);
    hit_valid = 1'b1; hit_dmg = 4'(dmg); cycle();
    hit_valid = 1'b0; hit_dmg = '0;
  endtask

  // Pause edge, optionally with a hit landing in the same cycle as the edge.
  task automatic pause_edge(input bit do_hit, input int dmg);
    btn_pause = 1'b1; cycle();
    hit_valid = do_hit; hit_dmg = 4'(dmg); cycle();
    hit_valid = 1'b0; hit_dmg = '0; btn_pause = 1'b0; cycle();
  endtask

  // Square-wave vsync of period 1000 for a number of periods; one tick each.
  task automatic vs_window(input string tag, input int periods);
    vs_period = 0; vsync = 1'b0; cycle(); cycle();
    tick_cnt = 0; vs_cnt = 0; vs_period = 1000;
    repeat (periods * 1000) cycle();
    vs_period = 0; vsync = 1'b0;
    check_eq(tag, 32'(tick_cnt), 32'(periods));
  endtask

  initial begin
    int budget;
    reset = 1'b0; vsync = 1'b1; btn_start = 1'b1; btn_pause = 1'b0;
    hit_valid = 1'b0; hit_dmg = '0; timer_done = 1'b0;

    // Reset with start and vsync held high: no spurious edges afterwards.
    repeat (3) cycle();
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_health", 32'(health), 32'd100);
    reset = 1'b1;
    tick_cnt = 0;
    repeat (4) cycle();
    check_eq("title_hold", 32'(state), 32'd0);
    check_eq("no_tick_after_rst", 32'(tick_cnt), 32'd0);

    btn_start = 1'b0; cycle();
    btn_start = 1'b1; cycle();
    check_eq("start_lat1", 32'(state), 32'd0);
    cycle();
    check_eq("start_lat2", 32'(state), 32'd1);

    vs_window("ticks_playing", 2);

    // Damage run with a stale timer_done already high.
    timer_done = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      hit(15);
      check_eq("hit_health", 32'(health), 32'(100 - 15 * k));
    end
    hit(15);
    check_eq("sat_health", 32'(health), 32'd0);
    check_eq("fatal_state", 32'(state), 32'd2);
    check_eq("fatal_tstart", 32'(timer_start), 32'd1);
    cycle();
    check_eq("stale_done_state", 32'(state), 32'd2);
    check_eq("tstart_pulse_end", 32'(timer_start), 32'd0);
    timer_done = 1'b0;

    vs_window("ticks_gameover", 2);
    check_eq("gameover_dwell", 32'(state), 32'd2);

    // Wait 120 ticks at a faster frame rate, then signal timer done.
    tick_cnt = 0; vs_cnt = 0; vs_period = 20; budget = 0;
    while (tick_cnt < 120 && budget < 5000) begin
      cycle();
      budget++;
    end
    check_eq("tick120_wait", 32'(tick_cnt), 32'd120);
    vs_period = 0; vsync = 1'b0;
    timer_done = 1'b1; cycle();
    timer_done = 1'b0;
    check_eq("done_to_title", 32'(state), 32'd0);
    check_eq("done_health", 32'(health), 32'd100);

    vs_window("ticks_title", 2);

    // Pause behaviour (inert without the pause feature).
    press_start();
    check_eq("restart", 32'(state), 32'd1);
    pause_edge(1'b0, 0);
    check_eq("pause_enter", 32'(state), PauseEn ? 32'd3 : 32'd1);
    hit(9);
    check_eq("pause_hit_ignored", 32'(health), PauseEn ? 32'd100 : 32'd91);
    pause_edge(1'b0, 0);
    check_eq("pause_exit", 32'(state), 32'd1);
    check_eq("pause_exit_health", 32'(health), PauseEn ? 32'd100 : 32'd91);
    pause_edge(1'b1, 5);
    check_eq("hit_pause_health", 32'(health), PauseEn ? 32'd95 : 32'd86);
    check_eq("hit_pause_state", 32'(state), PauseEn ? 32'd3 : 32'd1);
    pause_edge(1'b0, 0);
    check_eq("resume", 32'(state), 32'd1);

    budget = 0;
    while (m_health > 15 && budget < 20) begin
      hit(15);
      budget++;
    end
    btn_pause = 1'b1; cycle();
    hit(15);
    check_eq("fatal_pause_state", 32'(state), 32'd2);
    check_eq("fatal_pause_tstart", 32'(timer_start), 32'd1);

    // Reset while timer_start is high.
    btn_pause = 1'b0; reset = 1'b0; cycle();
    check_eq("rst_go_state", 32'(state), 32'd0);
    check_eq("rst_go_tstart", 32'(timer_start), 32'd0);
    check_eq("rst_go_health", 32'(health), 32'd100);
    reset = 1'b1;
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Top-level game-flow controller for the FP-Doom datapath. Sequences title screen, play, optional pause and game-over display, and tracks player health from damage events. Drives the two-second game-over timer directly: derives its 60 Hz `timer_tick` from VGA vsync, issues `timer_start`, and consumes `timer_done` to return to the title screen.

## Interface
- `HEALTH_MAX`, 100: health loaded at title/reset; must be 1..2^HEALTH_W-1
- `HEALTH_W`, 7: health counter width
- `DMG_W`, 4: damage field width
- `clk`  in  1  system clock
- `reset`  in  1  reset; synchronous, active-low: internal state is reset on a `clk` rising edge when `reset` is 0
- `vsync`  in  1  VGA vertical sync, level, synchronous to `clk`
- `btn_start`  in  1  debounced start button, level
- `btn_pause`  in  1  debounced pause button, level; ignored unless `GAME_PAUSE_EN`
- `hit_valid`  in  1  damage event strobe, one cycle per event
- `hit_dmg`  in  DMG_W  damage amount, qualified by `hit_valid`
- `timer_done`  in  1  game-over timer expired (level, may be stale high)
- `timer_start`  out  1  one-cycle load pulse to game-over timer
- `timer_tick`  out  1  one-cycle 60 Hz frame tick
- `state`  out  2  00 TITLE, 01 PLAYING, 10 GAMEOVER, 11 PAUSED
- `health`  out  HEALTH_W  current health
- `game_active`  out  1  high only in PLAYING
- `gameover_disp`  out  1  high only in GAMEOVER

## Operation
- Edge detect: `vsync`, `btn_start`, `btn_pause` each registered once; rise = current & ~previous. Previous-sample registers reset to 1, so a level already high during reset produces no edge.
- `timer_tick`: registered; high for exactly one cycle, the cycle after a vsync rise is detected. Free-running in all states.
- TITLE: `health` held at HEALTH_MAX; `btn_start` rise -> PLAYING. Hits ignored.
- PLAYING: on `hit_valid`, `health` <= health - hit_dmg, saturating at 0; `hit_dmg` = 0 leaves health unchanged. If the new health is 0 -> GAMEOVER. `btn_start` ignored.
- GAMEOVER: `timer_start` high in the first GAMEOVER cycle only. `timer_done` ignored in that cycle (stale from prior run); in any later GAMEOVER cycle `timer_done`=1 -> TITLE, health reloaded to HEALTH_MAX on the same edge. Hits and buttons ignored.
- PAUSED (macro only): hits ignored, health frozen; `btn_pause` rise -> PLAYING.
- Simultaneous events in PLAYING: hit is always applied; a fatal hit goes to GAMEOVER regardless of a same-cycle pause edge; a non-fatal hit plus pause edge applies the damage and enters PAUSED.
- Reset mid-operation: any state -> TITLE on the next edge; in-flight `timer_start` is dropped.

## Timing
- Reset values: `state`=TITLE, `health`=HEALTH_MAX, `timer_start`=0, `timer_tick`=0, `game_active`=0, `gameover_disp`=0.
- All outputs registered; `game_active`/`gameover_disp` decoded from the state register.
- Button/vsync level change to effect: 2 cycles (sample, edge register, state update visible after the following edge).
- `hit_valid` at cycle N -> `health` updated at N+1; fatal hit -> `state`=GAMEOVER and `timer_start`=1 at N+1, `timer_start`=0 at N+2.
- Minimum GAMEOVER dwell: 2 cycles.

## Configuration
- `GAME_PAUSE_EN` defined: PAUSED state and `btn_pause` edge detector present as described.
- Not defined: no PAUSED state, `btn_pause` unused, state code 11 never produced; a non-fatal hit with a simultaneous pause edge behaves as a plain hit.

## Test plan
- Reset with `btn_start` and `vsync` held high, release reset -> stays TITLE, no `timer_tick`, `health`=100; drop and raise `btn_start` -> PLAYING 2 cycles after the rise.
- PLAYING, hits of 15 x6 then 15 -> health 85,70,...,10 then 0 (saturated); GAMEOVER and single-cycle `timer_start` the cycle after the last hit.
- Enter GAMEOVER with `timer_done` held high -> stays GAMEOVER during the `timer_start` cycle; drive `timer_done` low then high after 120 ticks -> TITLE next cycle, health=100.
- vsync square wave period 1000 cycles -> exactly one `timer_tick` per period, 1 cycle wide, in every state.
- `GAME_PAUSE_EN`: pause in PLAYING -> PAUSED, hit of 9 ignored, pause again -> PLAYING with health unchanged; same-cycle fatal hit and pause edge -> GAMEOVER.
- Reset asserted in GAMEOVER the cycle `timer_start` is high -> next cycle TITLE, `timer_start`=0, health=100.
